// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared definitions for the data-memory responder: FSM state
//               encoding, word-index width helper and address error helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;

  localparam state_t C_ST_IDLE = 2'd0;
  localparam state_t C_ST_WAIT = 2'd1;
  localparam state_t C_ST_RESP = 2'd2;

  // Number of word-index bits needed to address a DEPTH-word array.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // A request is in error when it is not word aligned or when any address
  // bit above the word-index field is set.
  function automatic logic addr_error(input logic [1:0] low_bits,
                                      input logic       high_set);
    return (low_bits != 2'b00) || high_set;
  endfunction

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bus between the core load/store path
//               (master) and the data-memory responder (slave).
//               Optional macro DMEM_BYTE_STROBE_EN adds the req_be lanes.
// Signals     : req_valid/req_ready/req_write/req_addr/req_wdata[/req_be]
//               resp_valid/resp_ready/resp_rdata/resp_err
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
  parameter int AW = 32
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]    req_be;
`endif
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    output req_be,
`endif
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  req_be,
`endif
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_array
// Description : DEPTH x 32-bit single-port synchronous data array with
//               per-byte write enables. Contents are never reset. The read
//               register only updates when re is high, so read data stays
//               stable between reads.
// Ports       : clk   - clock, rising edge
//               we    - write strobe, be selects the byte lanes written
//               be    - byte-lane enables for the write
//               re    - read strobe, loads rdata from mem[idx]
//               idx   - word index
//               wdata - write data
//               rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder_array #(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (re) begin
      r_q <= r_mem[idx];
    end
  end

  assign rdata = r_q;

endmodule : dmem_responder_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the CPU data port. Accepts one
//               load/store per transaction, waits LATENCY cycles, then
//               presents the response until the core takes it. One request
//               outstanding at a time.
//               Optional macro DMEM_BYTE_STROBE_EN enables byte-lane stores
//               through bus.req_be; otherwise every store writes all lanes.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - dmem_responder_if.slave (request/response handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int         c_idx_w = idx_width(DEPTH);
  // Counter value on which WAIT hands over to RESP.
  localparam logic [3:0] c_last  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;

  logic                r_write;
  logic [AW-1:0]       r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;

  logic                w_hs;
  logic                w_resp_valid;
  logic                w_resp_hs;
  logic                w_enter_resp;
  logic                w_use_live;
  logic                w_write;
  logic [AW-1:0]       w_addr;
  logic [31:0]         w_wdata;
  logic [3:0]          w_be;
  logic [3:0]          w_live_be;
  logic                w_high;
  logic                w_err;
  logic                w_arr_we;
  logic                w_arr_re;
  logic [31:0]         w_arr_q;

`ifdef DMEM_BYTE_STROBE_EN
  assign w_live_be = bus.req_be;
`else
  assign w_live_be = 4'hF;
`endif

  assign w_hs         = bus.req_valid & (r_state == C_ST_IDLE);
  assign w_resp_valid = (r_state == C_ST_RESP);
  assign w_resp_hs    = w_resp_valid & bus.resp_ready;

  // With LATENCY == 0 the RESP entry edge is the handshake edge itself, so
  // the request must come straight from the bus; otherwise it comes from
  // the capture registers.
  assign w_use_live = (r_state == C_ST_IDLE);
  assign w_write    = w_use_live ? bus.req_write : r_write;
  assign w_addr     = w_use_live ? bus.req_addr  : r_addr;
  assign w_wdata    = w_use_live ? bus.req_wdata : r_wdata;
  assign w_be       = w_use_live ? w_live_be     : r_be;

  // Range check: any address bit above the word-index field is an error.
  generate
    if (AW > c_idx_w + 2) begin : g_range
      assign w_high = |w_addr[AW-1:c_idx_w+2];
    end else begin : g_no_range
      assign w_high = 1'b0;
    end
  endgenerate

  assign w_err = addr_error(w_addr[1:0], w_high);

  assign w_enter_resp = ((r_state == C_ST_IDLE) && w_hs && (LATENCY == 0)) ||
                        ((r_state == C_ST_WAIT) && (r_cnt == c_last));

  // Stores commit and loads sample the array only on the RESP entry edge,
  // so an aborted transaction never touches the array.
  assign w_arr_we = w_enter_resp &  w_write & ~w_err;
  assign w_arr_re = w_enter_resp & ~w_write & ~w_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (w_hs) begin
          w_state_nxt = (LATENCY == 0) ? C_ST_RESP : C_ST_WAIT;
        end
      end
      C_ST_WAIT: begin
        if (r_cnt == c_last) begin
          w_state_nxt = C_ST_RESP;
        end
      end
      C_ST_RESP: begin
        if (w_resp_hs) begin
          w_state_nxt = C_ST_IDLE;
        end
      end
      default: w_state_nxt = C_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if ((r_state == C_ST_WAIT) && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  // Request capture: held for the whole transaction, so later changes on
  // the request lines have no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
    end else if (w_hs) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_be    <= w_live_be;
    end
  end

  dmem_responder_array #(
    .DEPTH (DEPTH),
    .IW    (c_idx_w)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .be    (w_be),
    .re    (w_arr_re),
    .idx   (w_addr[c_idx_w+1:2]),
    .wdata (w_wdata),
    .rdata (w_arr_q)
  );

  assign bus.req_ready  = (r_state == C_ST_IDLE);
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_err   = w_resp_valid & w_err;
  assign bus.resp_rdata = (w_resp_valid && !r_write && !w_err) ? w_arr_q : 32'd0;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder
//               (DEPTH=1024, LATENCY=2). Byte-strobe steps are built only
//               when DMEM_BYTE_STROBE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int c_lat   = LATENCY + 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_responder_if #(.AW(32)) bus ();

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .AW      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request from a negedge and hold it until the handshake edge,
  // then scramble the request lines.
  task automatic handshake(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
    int g;
    g = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
`ifdef DMEM_BYTE_STROBE_EN
    bus.req_be    = be;
`else
    if (be != 4'hF) $display("note: byte enables ignored in this build");
`endif
    while (bus.req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  // Count negedges after the handshake edge until resp_valid is seen.
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.resp_valid !== 1'b1 && n < 20);
  endtask

  task automatic accept();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    handshake(wr, addr, wd, be);
    wait_resp(n);
    check({tag, "_lat"},   n,               c_lat);
    check({tag, "_rdata"}, bus.resp_rdata,  exp_rdata);
    check({tag, "_err"},   {31'd0, bus.resp_err}, {31'd0, exp_err});
    accept();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
    bus.req_be     = 4'hF;
`endif
    bus.resp_ready = 1'b0;
    reset          = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset_rdata",      bus.resp_rdata,          32'd0);
    check("reset_err",        {31'd0, bus.resp_err},   32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Known contents at 0x30, then hold reset with random requests
    txn("prep30", 1'b1, 32'h30, 32'h1111_1111, 4'hF, 32'd0, 1'b0);
    reset         = 1'b0;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rsthold_req_ready",  {31'd0, bus.req_ready},  32'd1);
      check("rsthold_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    end
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    txn("rsthold_nowrite", 1'b0, 32'h30, 32'd0, 4'hF, 32'h1111_1111, 1'b0);

    // Basic store / load
    txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'd0,         4'hF, 32'hDEAD_BEEF, 1'b0);

    // Errors
    txn("ld13_misalign", 1'b0, 32'h13,         32'd0, 4'hF, 32'd0, 1'b0 | 1'b1);
    txn("ld_oor",        1'b0, DEPTH * 4,      32'd0, 4'hF, 32'd0, 1'b1);
    txn("ld_highbit",    1'b0, 32'h8000_0010,  32'd0, 4'hF, 32'd0, 1'b1);
    txn("st11_misalign", 1'b1, 32'h11, 32'h5555_5555, 4'hF, 32'd0, 1'b1);
    txn("ld10_after_err",1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);

    // resp_ready while idle is ignored
    bus.resp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_ready_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("idle_ready_req_ready",  {31'd0, bus.req_ready},  32'd1);
    end
    bus.resp_ready = 1'b0;

    // Backpressure with a second request waiting
    handshake(1'b0, 32'h10, 32'd0, 4'hF);
    wait_resp(lat);
    check("bp_lat", lat, c_lat);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("bp_rdata",      bus.resp_rdata,          32'hDEAD_BEEF);
      check("bp_req_ready",  {31'd0, bus.req_ready},  32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    check("bp_release_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_after_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("bp_after_req_ready",  {31'd0, bus.req_ready},  32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    wait_resp(lat);
    check("bp_st40_lat", lat, c_lat);
    check("bp_st40_err", {31'd0, bus.resp_err}, 32'd0);
    accept();
    txn("ld40", 1'b0, 32'h40, 32'd0, 4'hF, 32'hCAFE_F00D, 1'b0);

    // Abort a store in WAIT with reset
    txn("st20_old", 1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF, 32'd0, 1'b0);
    handshake(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    @(negedge clk);
    check("abort_pre_req_ready", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    txn("ld20_after_abort", 1'b0, 32'h20, 32'd0, 4'hF, 32'hA5A5_A5A5, 1'b0);

`ifdef DMEM_BYTE_STROBE_EN
    txn("be_fill",  1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF,    32'd0, 1'b0);
    txn("be_0001",  1'b1, 32'h0, 32'h0000_00AA, 4'b0001, 32'd0, 1'b0);
    txn("be_ld1",   1'b0, 32'h0, 32'd0,         4'b0000, 32'hFFFF_FFAA, 1'b0);
    txn("be_0000",  1'b1, 32'h0, 32'h1234_5678, 4'b0000, 32'd0, 1'b0);
    txn("be_ld2",   1'b0, 32'h0, 32'd0,         4'hF,    32'hFFFF_FFAA, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
